// File: rtl/ws2812_bit_encoder_core.sv
// WS2812 single-bit line encoder.
// Each command sampled while cmd_req=1 becomes one slot: a TX slot of BIT_CYC
// cycles whose high phase length encodes the captured bit, or a LATCH slot of
// RESET_CYC low cycles. Slots chain back-to-back with no gap cycles.
// Build option: define WS2812_BIT_ENCODER_INVERT_EN to invert data_out
// everywhere, including its reset value, for inverting level shifters.
module ws2812_bit_encoder_core #(
  parameter int BIT_CYC   = 4,
  parameter int T0H_CYC   = 1,
  parameter int T1H_CYC   = 3,
  parameter int RESET_CYC = 200
) (
  input  logic       databit,
  input  logic       clk,
  input  logic [1:0] cmd,
  output logic       cmd_req,
  output logic       data_out,
  input  logic       rst
);

`ifdef WS2812_BIT_ENCODER_INVERT_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  localparam int MAXC = (BIT_CYC > RESET_CYC) ? BIT_CYC : RESET_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYC - 1);

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_TX    = 2'b01;
  localparam logic [1:0] CMD_RESET = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    TX,
    LATCH
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          bit_q, bit_n;
  logic          out_n;

  // Sampling point: always in IDLE, otherwise the last cycle of a slot.
  assign cmd_req = (state == IDLE) ||
                   ((state == TX)    && (cnt == BIT_LAST)) ||
                   ((state == LATCH) && (cnt == RST_LAST));

  // State, slot counter, captured bit and registered line output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_q    <= 1'b0;
      data_out <= INV;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_q    <= bit_n;
      data_out <= out_n ^ INV;
    end
  end

  // Next state plus the line level for the next cycle, so data_out stays a
  // plain flop with no path from cmd or databit to the pin.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_q;
    out_n   = 1'b0;
    if (cmd_req) begin
      cnt_n = '0;
      case (cmd)
        CMD_TX: begin
          state_n = TX;
          bit_n   = databit;
          out_n   = 1'b1;
        end
        CMD_RESET: begin
          state_n = LATCH;
        end
        CMD_IDLE: begin
          state_n = IDLE;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end else begin
      cnt_n = cnt + 1'b1;
      if (state == TX) begin
        out_n = (int'(cnt) + 1) < (bit_q ? T1H_CYC : T0H_CYC);
      end
    end
  end

endmodule

// File: tb/tb_ws2812_bit_encoder_core.sv
// Testbench for ws2812_bit_encoder_core: table-driven slot sequences with a
// queue of expected {data_out, cmd_req} per cycle, plus hand-written latch,
// mid-slot databit change and mid-slot reset sequences.
module tb_ws2812_bit_encoder_core;

`ifdef WS2812_BIT_ENCODER_INVERT_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       databit;
  logic [1:0] cmd;
  logic       cmd_req;
  logic       data_out;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] cmd;
    logic       bitv;
    int         slots;
    logic [3:0] out_pat;
    logic [3:0] req_pat;
  } vec_t;

  vec_t tbl[7];
  logic [1:0] exp_q[$];

  ws2812_bit_encoder_core #(
    .BIT_CYC  (4),
    .T0H_CYC  (1),
    .T1H_CYC  (3),
    .RESET_CYC(200)
  ) dut (
    .databit (databit),
    .clk     (clk),
    .cmd     (cmd),
    .cmd_req (cmd_req),
    .data_out(data_out),
    .rst     (rst)
  );

  always #5 clk = ~clk;

  task automatic push_pat(input logic [3:0] o, input logic [3:0] r);
    for (int unsigned i = 0; i < 4; i++) begin
      exp_q.push_back({o[3-i], r[3-i]});
    end
  endtask

  task automatic step_cmp(input string nm);
    logic [1:0] e;
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: scoreboard empty, got out=%b req=%b", nm, data_out, cmd_req);
    end else begin
      e = exp_q.pop_front();
      if ({data_out, cmd_req} !== {e[1] ^ INV, e[0]}) begin
        failures++;
        $display("FAIL %s t=%0t: got out=%b req=%b, expected out=%b req=%b",
                 nm, $time, data_out, cmd_req, e[1] ^ INV, e[0]);
      end
    end
  endtask

  task automatic direct_cmp(input string nm, input logic eo, input logic er);
    checks++;
    if ({data_out, cmd_req} !== {eo, er}) begin
      failures++;
      $display("FAIL %s t=%0t: got out=%b req=%b, expected out=%b req=%b",
               nm, $time, data_out, cmd_req, eo, er);
    end
  endtask

  initial begin
    tbl[0] = '{cmd: 2'b01, bitv: 1'b0, slots: 3, out_pat: 4'b1000, req_pat: 4'b0001};
    tbl[1] = '{cmd: 2'b01, bitv: 1'b1, slots: 3, out_pat: 4'b1110, req_pat: 4'b0001};
    tbl[2] = '{cmd: 2'b01, bitv: 1'b0, slots: 2, out_pat: 4'b1000, req_pat: 4'b0001};
    tbl[3] = '{cmd: 2'b00, bitv: 1'b1, slots: 1, out_pat: 4'b0000, req_pat: 4'b1111};
    tbl[4] = '{cmd: 2'b11, bitv: 1'b1, slots: 1, out_pat: 4'b0000, req_pat: 4'b1111};
    tbl[5] = '{cmd: 2'b01, bitv: 1'b1, slots: 2, out_pat: 4'b1110, req_pat: 4'b0001};
    tbl[6] = '{cmd: 2'b00, bitv: 1'b0, slots: 1, out_pat: 4'b0000, req_pat: 4'b1111};

    rst     = 1'b1;
    cmd     = 2'b00;
    databit = 1'b0;
    #2;
    direct_cmp("reset_async", INV, 1'b1);
    @(posedge clk);
    #1;
    direct_cmp("reset_held", INV, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    direct_cmp("after_release", INV, 1'b1);

    // Table-driven slot streams; each entry starts at a sampling point.
    for (int unsigned v = 0; v < 7; v++) begin
      cmd     = tbl[v].cmd;
      databit = tbl[v].bitv;
      for (int s = 0; s < tbl[v].slots; s++) begin
        push_pat(tbl[v].out_pat, tbl[v].req_pat);
      end
      for (int c = 0; c < 4 * tbl[v].slots; c++) begin
        step_cmp($sformatf("vec%0d_c%0d", v, c));
      end
    end

    // databit flips mid-slot: current slot keeps 0, next encodes 1.
    cmd     = 2'b01;
    databit = 1'b0;
    push_pat(4'b1000, 4'b0001);
    push_pat(4'b1110, 4'b0001);
    step_cmp("midbit_c0");
    databit = 1'b1;
    for (int c = 1; c < 8; c++) begin
      step_cmp($sformatf("midbit_c%0d", c));
    end

    // LATCH: 200 low cycles, cmd_req only in the last; cmd wiggled mid-slot.
    cmd = 2'b10;
    for (int i = 1; i <= 200; i++) begin
      exp_q.push_back({1'b0, (i == 200)});
    end
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(2'b01);
    end
    step_cmp("latch_c1");
    cmd     = 2'b01;
    databit = 1'b1;
    for (int i = 2; i <= 199; i++) begin
      step_cmp($sformatf("latch_c%0d", i));
    end
    cmd = 2'b00;
    step_cmp("latch_c200");
    for (int i = 0; i < 3; i++) begin
      step_cmp($sformatf("post_latch_idle%0d", i));
    end

    // Reset during the high phase of a 1 bit.
    cmd     = 2'b01;
    databit = 1'b1;
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b10);
    step_cmp("pre_rst_c0");
    step_cmp("pre_rst_c1");
    #2;
    rst = 1'b1;
    #1;
    direct_cmp("midslot_rst_async", INV, 1'b1);
    @(posedge clk);
    #1;
    direct_cmp("midslot_rst_held", INV, 1'b1);
    #2;
    rst = 1'b0;
    push_pat(4'b1110, 4'b0001);
    for (int c = 0; c < 4; c++) begin
      step_cmp($sformatf("post_rst_c%0d", c));
    end
    cmd = 2'b00;
    exp_q.push_back(2'b01);
    step_cmp("final_idle");

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
